layer_output_streamer: RTL

LAYER_OUTPUT_STREAMER -- requirements
Module: layer_output_streamer

---
 rtl/layer_output_streamer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/layer_output_streamer.sv
// Captures a dense layer's result vector on the rising edge of output_ready and
// streams it one word per handshake, reporting the argmax once the last word is accepted.
module layer_output_streamer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_NEURONS = 16,
    localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         output_ready,
    input  logic signed [DATA_WIDTH-1:0] outputs [NUM_NEURONS],
    output logic signed [DATA_WIDTH-1:0] stream_data,
    output logic                         stream_valid,
    input  logic                         stream_ready,
    output logic [IDX_W-1:0]             stream_index,
    output logic                         stream_last,
    output logic                         busy,
    output logic [IDX_W-1:0]             argmax,
    output logic                         argmax_valid,
    output logic                         overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                       state_q, state_d;
    logic                         prev_rdy_q;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] buf_q [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0]             max_idx_q, max_idx_d;
    logic [IDX_W-1:0]             argmax_q, argmax_d;
    logic                         overrun_q, overrun_d;
    logic                         capture_evt;
    logic                         load_buf;
    logic signed [DATA_WIDTH-1:0] word;

    always_comb begin
        capture_evt  = output_ready & ~prev_rdy_q;
        word         = buf_q[idx_q];
        state_d      = state_q;
        idx_d        = idx_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        argmax_d     = argmax_q;
        overrun_d    = overrun_q;
        load_buf     = 1'b0;
        stream_valid = 1'b0;
        argmax_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_evt) begin
                    load_buf = 1'b1;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                stream_valid = 1'b1;
                if (capture_evt) overrun_d = 1'b1;
                if (stream_ready) begin
                    // Strict compare keeps the lowest index on ties; index 0 always seeds the max.
                    if ((idx_q == '0) || (word > max_q)) begin
                        max_d     = word;
                        max_idx_d = idx_q;
                    end
                    if (idx_q == LAST) begin
                        argmax_d = max_idx_d;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                argmax_valid = 1'b1;
                if (capture_evt) overrun_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_rdy_q <= 1'b0;
            idx_q      <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            argmax_q   <= '0;
            overrun_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            prev_rdy_q <= output_ready;
            idx_q      <= idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            argmax_q   <= argmax_d;
            overrun_q  <= overrun_d;
            if (load_buf) begin
                for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                    buf_q[i] <= outputs[i];
                end
            end
        end
    end

    assign stream_data  = stream_valid ? word : '0;
    assign stream_index = stream_valid ? idx_q : '0;
    assign stream_last  = stream_valid && (idx_q == LAST);
    assign busy         = (state_q != IDLE);
    assign argmax       = argmax_q;
    assign overrun      = overrun_q;

endmodule
